result_serializer: RTL and testbench

//   Output stage of the UART matrix-multiply datapath. After the multiplier finishes,

---
 rtl/result_serializer.sv | 186 ++++++++++++++++++
 tb/tb_result_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Result serializer: reads the N x N result matrix from the result buffer in
// row-major order and sends each element to the UART transmitter as bytes,
// high byte first, using the tx_start / tx_busy handshake.
module result_serializer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int MAX_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [BCNT_W-1:0] BYTE_ONE  = BCNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [3:0]        MAX_N     = 4'(MAX_SIZE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_GUARD  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        total_q, total_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BCNT_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              res_rd_en_q, res_rd_en_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0]        n_clamp;
  logic [DATA_W-1:0] shifted;

  // Requests larger than the supported matrix are clamped to MAX_SIZE.
  assign n_clamp = (matrix_size > MAX_N) ? MAX_N : matrix_size;
  assign shifted = shift_q << 8;

  // Next-state and registered-output computation for the serializer FSM.
  // tx_start is registered, so the idle check on tx_busy is made one cycle
  // ahead: on entry to SEND (from LATCH or WAIT) and while stalled in SEND.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    shift_d     = shift_q;
    res_rd_en_d = 1'b0;
    res_addr_d  = res_addr_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d = {4'b0000, n_clamp} * {4'b0000, n_clamp};
          busy_d  = 1'b1;
          idx_d   = '0;
          byte_d  = '0;
          if (n_clamp == 4'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_FETCH;
            res_rd_en_d = 1'b1;
            res_addr_d  = '0;
          end
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_d = res_data;
        byte_d  = '0;
        state_d = S_SEND;
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = res_data[DATA_W-1 -: 8];
        end
      end
      S_SEND: begin
        if (tx_start_q) begin
          state_d = S_GUARD;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = shift_q[DATA_W-1 -: 8];
        end
      end
      S_GUARD: begin
        // tx_busy only rises the cycle after tx_start, so it is not trusted here.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (byte_q != LAST_BYTE) begin
            byte_d     = byte_q + BYTE_ONE;
            shift_d    = shifted;
            tx_start_d = 1'b1;
            tx_data_d  = shifted[DATA_W-1 -: 8];
            state_d    = S_SEND;
          end else if (8'(idx_q) < (total_q - 8'd1)) begin
            idx_d       = idx_q + ADDR_ONE;
            res_rd_en_d = 1'b1;
            res_addr_d  = idx_q + ADDR_ONE;
            state_d     = S_FETCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        // First FINISH cycle raises done (registered); second returns to IDLE.
        // start is ignored throughout.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and all outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      total_q     <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      res_rd_en_q <= 1'b0;
      res_addr_q  <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      res_rd_en_q <= res_rd_en_d;
      res_addr_q  <= res_addr_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Element shift register; always reloaded in LATCH before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign res_rd_en = res_rd_en_q;
  assign res_addr  = res_addr_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Directed testbench for result_serializer with a registered result buffer
// model and a UART model that stays busy for a programmable number of cycles.
module tb_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  matrix_size;
  logic        res_rd_en;
  logic [5:0]  res_addr;
  logic [15:0] res_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done;

  result_serializer #(.DATA_W(16), .ADDR_W(6), .MAX_SIZE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_size (matrix_size),
    .res_rd_en   (res_rd_en),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Result buffer: data valid one cycle after the read strobe.
  logic [15:0] mem [0:63];
  always @(posedge clk) begin
    if (res_rd_en) res_data <= mem[res_addr];
  end

  // UART: busy rises the cycle after tx_start and stays high busy_len cycles.
  int   busy_len   = 10;
  logic force_busy = 1'b0;
  int   ucnt       = 0;
  always @(posedge clk) begin
    if (tx_start) ucnt <= busy_len;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign tx_busy = force_busy | (ucnt > 0);

  // Activity monitor sampled on the falling edge.
  logic       mon_clr = 1'b0;
  int         nbytes = 0, nreads = 0, ndone = 0, nbusy = 0;
  logic [7:0] bytes [0:255];
  int         rd_cnt [0:63];
  logic [5:0] last_addr = '0;
  always @(negedge clk) begin
    if (mon_clr) begin
      nbytes <= 0;
      nreads <= 0;
      ndone  <= 0;
      nbusy  <= 0;
      for (int i = 0; i < 64; i++) rd_cnt[i] <= 0;
    end else begin
      if (tx_start) begin
        bytes[nbytes[7:0]] <= tx_data;
        nbytes <= nbytes + 1;
      end
      if (res_rd_en) begin
        rd_cnt[res_addr] <= rd_cnt[res_addr] + 1;
        nreads    <= nreads + 1;
        last_addr <= res_addr;
      end
      if (done) ndone <= ndone + 1;
      if (busy) nbusy <= nbusy + 1;
    end
  end

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_rd_en"},    32'(res_rd_en), 32'd0);
    check({pfx, "_addr"},     32'(res_addr),  32'd0);
    check({pfx, "_tx_data"},  32'(tx_data),   32'd0);
    check({pfx, "_tx_start"}, 32'(tx_start),  32'd0);
    check({pfx, "_busy"},     32'(busy),      32'd0);
    check({pfx, "_done"},     32'(done),      32'd0);
  endtask

  task automatic pulse_start(input logic [3:0] n);
    @(negedge clk);
    start       = 1'b1;
    matrix_size = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_mon();
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic load_t1_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h0001;
    mem[3] = 16'hFF00;
  endtask

  logic [7:0] exp1 [0:7] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};

  initial begin
    int seen;
    rst         = 1'b1;
    start       = 1'b0;
    matrix_size = 4'd0;
    for (int k = 0; k < 64; k++) mem[k] = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst = 1'b0;

    // 1: N=2, UART busy 10 cycles per byte
    load_t1_mem();
    busy_len = 10;
    clear_mon();
    pulse_start(4'd2);
    check("t1_rd_en_t1", 32'(res_rd_en), 32'd1);
    check("t1_addr_t1",  32'(res_addr),  32'd0);
    check("t1_busy_t1",  32'(busy),      32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t1_tx_start_t3", 32'(tx_start), 32'd1);
    check("t1_tx_data_t3",  32'(tx_data),  32'h12);
    wait_done(500, "t1_done_seen");
    settle();
    check("t1_nbytes", 32'(nbytes), 32'd8);
    for (int i = 0; i < 8; i++) check("t1_byte", 32'(bytes[i]), 32'(exp1[i]));
    check("t1_ndone", 32'(ndone), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: N=0, no reads or bytes, done two cycles after start
    clear_mon();
    pulse_start(4'd0);
    check("t2_busy_t1", 32'(busy), 32'd1);
    check("t2_done_t1", 32'(done), 32'd0);
    @(negedge clk);
    check("t2_done_t2", 32'(done), 32'd1);
    check("t2_busy_t2", 32'(busy), 32'd0);
    @(negedge clk);
    check("t2_done_t3", 32'(done), 32'd0);
    settle();
    check("t2_nreads", 32'(nreads), 32'd0);
    check("t2_nbytes", 32'(nbytes), 32'd0);
    check("t2_nbusy",  32'(nbusy),  32'd1);
    check("t2_ndone",  32'(ndone),  32'd1);

    // 3: N=3 with the UART held busy 50 cycles before the first byte
    for (int k = 0; k < 64; k++) mem[k] = {8'(k), 8'(k) + 8'h80};
    clear_mon();
    force_busy = 1'b1;
    pulse_start(4'd3);
    @(negedge clk);
    @(negedge clk);
    check("t3_stall_t3", 32'(tx_start), 32'd0);
    repeat (47) @(negedge clk);
    #1;
    check("t3_held_nbytes", 32'(nbytes), 32'd0);
    force_busy = 1'b0;
    wait_done(1000, "t3_done_seen");
    settle();
    check("t3_nbytes", 32'(nbytes), 32'd18);
    check("t3_nreads", 32'(nreads), 32'd9);
    for (int k = 0; k < 9; k++) check("t3_rd_once", 32'(rd_cnt[k]), 32'd1);
    check("t3_byte0",  32'(bytes[0]),  32'h00);
    check("t3_byte1",  32'(bytes[1]),  32'h80);
    check("t3_byte16", 32'(bytes[16]), 32'h08);
    check("t3_byte17", 32'(bytes[17]), 32'h88);

    // 4: matrix_size=12 clamps to 8 -> 64 elements
    busy_len = 2;
    clear_mon();
    pulse_start(4'd12);
    wait_done(5000, "t4_done_seen");
    settle();
    check("t4_nbytes",    32'(nbytes),     32'd128);
    check("t4_nreads",    32'(nreads),     32'd64);
    check("t4_last_addr", 32'(last_addr),  32'd63);
    check("t4_byte126",   32'(bytes[126]), 32'h3F);
    check("t4_byte127",   32'(bytes[127]), 32'hBF);

    // 5: second start mid-transfer is ignored
    load_t1_mem();
    busy_len = 10;
    clear_mon();
    pulse_start(4'd2);
    repeat (20) @(negedge clk);
    pulse_start(4'd1);
    wait_done(500, "t5_done_seen");
    settle();
    check("t5_nbytes", 32'(nbytes), 32'd8);
    for (int i = 0; i < 8; i++) check("t5_byte", 32'(bytes[i]), 32'(exp1[i]));
    check("t5_nreads", 32'(nreads), 32'd4);
    check("t5_ndone",  32'(ndone),  32'd1);

    // 6: reset after the third byte, then a fresh N=1 transfer
    clear_mon();
    pulse_start(4'd2);
    seen = 0;
    for (int i = 0; i < 300 && seen < 3; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen++;
    end
    check("t6_third_byte_seen", 32'(seen), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("t6");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("t6_nbytes_after_rst", 32'(nbytes), 32'd3);
    check("t6_ndone_after_rst",  32'(ndone),  32'd0);
    mem[0] = 16'h5AA5;
    clear_mon();
    pulse_start(4'd1);
    wait_done(500, "t6_done_seen");
    settle();
    check("t6_nbytes_n1", 32'(nbytes),   32'd2);
    check("t6_byte0",     32'(bytes[0]), 32'h5A);
    check("t6_byte1",     32'(bytes[1]), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
